// File: rtl/uart_rx_framer_if.sv
// Receive-side handshake between the UART RX framer and the RX FIFO write port.
// The framer is the master: it drives the byte, the write strobe and the status pulses.
interface uart_rx_framer_if #(
  parameter int DATA_BITS = 8
);
  logic                 fifo_full;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  fifo_full,
    output data_out,
    output data_valid,
    output frame_err,
    output overrun,
    output busy
  );

  modport slave (
    output fifo_full,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  overrun,
    input  busy
  );
endinterface

// File: rtl/uart_rx_framer.sv
// Framed UART receiver: synchronises the line, validates the start bit, samples data
// bits at mid-bit, checks the stop bit and emits one write strobe or error pulse per frame.
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  uart_rx_framer_if.master fifo_if
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift_reg, shift_n;
  logic [DATA_BITS-1:0] data_reg, data_n;
  logic                 valid_q, valid_n;
  logic                 ferr_q, ferr_n;
  logic                 ovr_q, ovr_n;
  logic                 rx_meta, rx_s;

  // Synchroniser flops come out of reset high so an idle line is not seen as a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_reg  <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shift_reg <= shift_n;
      data_reg  <= data_n;
      valid_q   <= valid_n;
      ferr_q    <= ferr_n;
      ovr_q     <= ovr_n;
    end
  end

  // Data arrives LSB first, so shifting in from the top leaves bit 0 in place after the last bit.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_reg;
    data_n    = data_reg;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    ovr_n     = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (!rx_s) begin
          state_n = START;
        end
      end

      START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            bit_idx_n = '0;
            state_n   = STOP;
          end else begin
            bit_idx_n = bit_idx + IDX_W'(1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Leaving at mid-stop-bit lets a following start bit be caught with no idle gap.
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = IDLE;
            if (fifo_if.fifo_full) begin
              ovr_n = 1'b1;
            end else begin
              data_n  = shift_reg;
              valid_n = 1'b1;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      WAIT_IDLE: begin
        cnt_n = '0;
        if (rx_s) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign fifo_if.data_out   = data_reg;
  assign fifo_if.data_valid = valid_q;
  assign fifo_if.frame_err  = ferr_q;
  assign fifo_if.overrun    = ovr_q;
  assign fifo_if.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: table vectors, randomised frames against a
// frame-level outcome model, and hand-written glitch/break/back-to-back/reset sequences.
module tb_uart_rx_framer;

  localparam int C     = 16;
  localparam int D     = 8;
  localparam int H     = C / 2;
  localparam int LAT   = 2 + H + (D + 1) * C + 1;
  localparam int FRAME = (D + 2) * C;
  localparam int NV    = 7;
  localparam int NR    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx_in = 1'b1;

  always #5 clk = ~clk;

  uart_rx_framer_if #(.DATA_BITS(D)) bus ();

  uart_rx_framer #(
    .CLKS_PER_BIT(C),
    .DATA_BITS   (D)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_in  (rx_in),
    .fifo_if(bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       full;
    int         gap;
    int         exp_valid;
    int         exp_ovr;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         n_valid, n_ferr, n_ovr, pulse_cyc, start_cyc;
  logic       seen_busy;
  int         valid_cyc[$];
  logic [7:0] valid_data[$];
  vec_t       table_v[NV];
  vec_t       rv;
  logic [7:0] model_data;
  logic [7:0] frame_byte;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One clock: observe just after the rising edge and log any pulse that appeared.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.data_valid === 1'b1) begin
      n_valid++;
      valid_cyc.push_back(cyc);
      valid_data.push_back(bus.data_out);
    end
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.overrun === 1'b1) n_ovr++;
    if ((bus.data_valid === 1'b1 || bus.frame_err === 1'b1 || bus.overrun === 1'b1) && pulse_cyc < 0)
      pulse_cyc = cyc;
    if (bus.busy === 1'b1) seen_busy = 1'b1;
  endtask

  task automatic clearObs();
    n_valid   = 0;
    n_ferr    = 0;
    n_ovr     = 0;
    pulse_cyc = -1;
    seen_busy = 1'b0;
    valid_cyc.delete();
    valid_data.delete();
  endtask

  task automatic sendBit(input logic b);
    rx_in = b;
    repeat (C) tick();
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stop);
    sendBit(1'b0);
    for (int i = 0; i < D; i++) sendBit(d[i]);
    sendBit(stop);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    clearObs();
    bus.fifo_full = v.full;
    start_cyc = cyc;
    sendFrame(v.data, v.stop);
    rx_in = 1'b1;
    bus.fifo_full = 1'b0;
    repeat (v.gap) tick();
    checkOutput({tag, " valid_cnt"}, n_valid, v.exp_valid);
    checkOutput({tag, " overrun_cnt"}, n_ovr, v.exp_ovr);
    checkOutput({tag, " frame_err_cnt"}, n_ferr, v.exp_ferr);
    checkOutput({tag, " data_out"}, bus.data_out, v.exp_data);
    checkOutput({tag, " latency"}, pulse_cyc - start_cyc, LAT);
    checkOutput({tag, " busy_seen"}, seen_busy, 1'b1);
    if (v.gap >= 4) checkOutput({tag, " busy_after"}, bus.busy, 1'b0);
  endtask

  initial begin
    table_v[0] = '{8'hA5, 1'b1, 1'b0, 20, 1, 0, 0, 8'hA5};
    table_v[1] = '{8'h81, 1'b1, 1'b1, 20, 0, 1, 0, 8'hA5};
    table_v[2] = '{8'h3C, 1'b0, 1'b0, 20, 0, 0, 1, 8'hA5};
    table_v[3] = '{8'h3C, 1'b0, 1'b1, 20, 0, 0, 1, 8'hA5};
    table_v[4] = '{8'h00, 1'b1, 1'b0, 20, 1, 0, 0, 8'h00};
    table_v[5] = '{8'hFF, 1'b1, 1'b1, 20, 0, 1, 0, 8'h00};
    table_v[6] = '{8'h5A, 1'b1, 1'b0, 20, 1, 0, 0, 8'h5A};

    bus.fifo_full = 1'b0;
    clearObs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset data_out", bus.data_out, 8'h00);
    checkOutput("reset data_valid", bus.data_valid, 1'b0);
    checkOutput("reset frame_err", bus.frame_err, 1'b0);
    checkOutput("reset overrun", bus.overrun, 1'b0);
    checkOutput("reset busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) tick();

    $display("[TB] table vectors");
    for (int i = 0; i < NV; i++) applyStimulus(table_v[i], $sformatf("vec%0d", i));

    // Frame-level model: a good stop bit either delivers the byte or drops it when full.
    $display("[TB] randomised frames");
    model_data = table_v[NV-1].exp_data;
    for (int r = 0; r < NR; r++) begin
      rv.data = 8'($urandom_range(0, 255));
      rv.stop = ($urandom_range(0, 3) != 0);
      rv.full = ($urandom_range(0, 2) == 0);
      rv.gap  = rv.stop ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 8));
      rv.exp_valid = (rv.stop && !rv.full) ? 1 : 0;
      rv.exp_ovr   = (rv.stop && rv.full) ? 1 : 0;
      rv.exp_ferr  = rv.stop ? 0 : 1;
      if (rv.exp_valid == 1) model_data = rv.data;
      rv.exp_data  = model_data;
      applyStimulus(rv, $sformatf("rand%0d", r));
    end
    rx_in = 1'b1;
    repeat (20) tick();

    $display("[TB] rejected start");
    clearObs();
    rx_in = 1'b0;
    repeat (4) tick();
    rx_in = 1'b1;
    repeat (30) tick();
    checkOutput("glitch pulses", n_valid + n_ferr + n_ovr, 0);
    checkOutput("glitch busy_seen", seen_busy, 1'b1);
    checkOutput("glitch busy_after", bus.busy, 1'b0);
    checkOutput("glitch data_out", bus.data_out, model_data);

    $display("[TB] break after bad stop bit");
    clearObs();
    start_cyc = cyc;
    sendFrame(8'h3C, 1'b0);
    repeat (40) tick();
    checkOutput("break frame_err_cnt", n_ferr, 1);
    checkOutput("break latency", pulse_cyc - start_cyc, LAT);
    checkOutput("break busy_low_line", bus.busy, 1'b1);
    rx_in = 1'b1;
    repeat (20) tick();
    checkOutput("break busy_after", bus.busy, 1'b0);
    checkOutput("break valid_cnt", n_valid, 0);
    checkOutput("break frame_err_final", n_ferr, 1);
    checkOutput("break data_out", bus.data_out, model_data);

    $display("[TB] back-to-back frames");
    clearObs();
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    rx_in = 1'b1;
    repeat (20) tick();
    checkOutput("b2b valid_cnt", n_valid, 2);
    checkOutput("b2b err_cnt", n_ferr + n_ovr, 0);
    if (valid_cyc.size() == 2) begin
      checkOutput("b2b first_data", valid_data[0], 8'h00);
      checkOutput("b2b second_data", valid_data[1], 8'hFF);
      checkOutput("b2b spacing", valid_cyc[1] - valid_cyc[0], FRAME);
    end

    $display("[TB] reset mid-frame");
    frame_byte = 8'hC3;
    clearObs();
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(frame_byte[i]);
    rx_in = frame_byte[3];
    repeat (H) tick();
    checkOutput("midreset busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    checkOutput("midreset data_out", bus.data_out, 8'h00);
    checkOutput("midreset data_valid", bus.data_valid, 1'b0);
    checkOutput("midreset frame_err", bus.frame_err, 1'b0);
    checkOutput("midreset overrun", bus.overrun, 1'b0);
    checkOutput("midreset busy", bus.busy, 1'b0);
    #20;
    rst_n = 1'b1;
    clearObs();
    repeat (10) tick();
    start_cyc = cyc;
    sendFrame(8'h5A, 1'b1);
    repeat (20) tick();
    checkOutput("midreset valid_cnt", n_valid, 1);
    checkOutput("midreset err_cnt", n_ferr + n_ovr, 0);
    checkOutput("midreset new_data", bus.data_out, 8'h5A);
    checkOutput("midreset latency", pulse_cyc - start_cyc, LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
